mold_feed_arbiter: RTL and testbench
====================================

Name: mold_feed_arbiter

Overview:
- Packet-granular A/B line arbiter placed between two eth_udp_parser instances (feed A, feed B) and the order-book builder.
- Each input is one MoldUDP64 packet's ITCH payload byte stream, with the packet's sequence number and message count held as side-band metadata.
- Forwards each sequence range exactly once, in sequence order.
- Drops duplicates and heartbeats, flags gaps, and keeps the expected next sequence number.

Parameters:
- SEQ_W, 64, sequence number width.
- CNT_W, 16, message count width.
- STAT_W, 32, width of the statistics counters.

Ports:
- clkIn  input  1  clock; single clock domain.
- rstIn  input  1  synchronous, active-high reset.
- aValidIn  input  1  feed A byte valid.
- aDataIn  input  8  feed A payload byte.
- aLastIn  input  1  last byte of feed A packet.
- aSeqNumIn  input  SEQ_W  feed A packet sequence number; stable from first beat through last beat.
- aMsgCntIn  input  CNT_W  feed A message count; stable from first beat through last beat.
- aReadyOut  output  1  feed A byte accepted.
- bValidIn, bDataIn, bLastIn, bSeqNumIn, bMsgCntIn, bReadyOut: same as feed A, for feed B.
- outValidOut  output  1  forwarded byte valid.
- outDataOut  output  8  forwarded byte.
- outLastOut  output  1  last forwarded byte of packet.
- outReadyIn  input  1  downstream ready.
- gapOut  output  1  one-cycle pulse when a gap is detected.
- gapSizeOut  output  STAT_W  missing message count; saturates at all-ones.
- expSeqNumOut  output  SEQ_W  expected next sequence number.
- syncedOut  output  1  first packet has been accepted.
- dupDropCntOut  output  STAT_W  dropped-packet counter; saturating.
- gapCntOut  output  STAT_W  gap-event counter; saturating.

Behaviour:
- Reset: every output is 0, state is IDLE, lastGrant=B.
- A byte transfers on a side when valid & ready are both 1.
- States: IDLE, FWD_A, FWD_B, DROP_A, DROP_B.
- IDLE: both readys are 0 and outValidOut is 0.
  - Candidates are the feeds with validIn=1.
  - If both feeds are candidates, the lower seqNum wins. On equal seqNum, the feed other than lastGrant wins.
  - For the winner, with end = seq + msgCnt (modulo 2^SEQ_W):
  - If msgCnt==0, or (synced and end <= exp): go to DROP_x and increment dupDropCnt.
  - Else if !synced: go to FWD_x; exp<=end; synced<=1; no gap.
  - Else if seq > exp: go to FWD_x; exp<=end; gapOut=1 next cycle; gapSizeOut<=min(seq-exp, 2^STAT_W-1); increment gapCnt.
  - Else (seq <= exp < end, including partial overlap): go to FWD_x; exp<=end; no gap.
  - The decision is registered, and lastGrant is updated to the winner.
- FWD_x: forwarding of the selected feed is combinational.
  - outValidOut=xValidIn, outDataOut=xDataIn, outLastOut=xLastIn, xReadyOut=outReadyIn.
  - The other feed's readyOut is 0.
  - On a transfer with last=1, return to IDLE.
- DROP_x: xReadyOut=1; outValidOut=0; the other feed's ready is 0. On a transfer with last=1, return to IDLE.
- Latency:
  - Head byte at cycle N while in IDLE: the state changes at N+1, and the first byte is presented at N+1.
  - There is one bubble cycle between consecutive packets.
- Backpressure: outReadyIn=0 holds the granted feed stalled; no byte is lost or duplicated.
- Boundary conditions:
  - Valid on a non-granted feed waits; it is never consumed while the other feed holds the grant.
  - A single-byte packet (valid & last on the first beat) returns to IDLE after one transfer.
  - Metadata changing mid-packet is ignored; it is sampled only in IDLE.
  - Statistics counters saturate at all-ones.
  - Reset mid-packet aborts the packet immediately. The remainder of an interrupted input packet is then judged as a new packet.

Test Plan:
- Syncing and duplicate drop: A and B present identical packets seq=100, cnt=3 in the same cycle.
  - Required: A is forwarded (lastGrant=B at reset), then B is dropped.
  - Required after both: exp=103, dupDropCnt=1, gapOut never pulses.
- Gap: with exp=103, A seq=110, cnt=2.
  - Required: forwarded; gapOut pulses 1 cycle; gapSizeOut=7; gapCnt=1; exp=112.
- Partial overlap and ordering: with exp=112, A seq=115 and B seq=110, cnt=4, both valid.
  - Required: B is granted first and forwarded, exp=114.
  - Required next: A is forwarded, gapSizeOut=1, exp=117.
- Heartbeat: B seq=117, cnt=0, 1 byte.
  - Required: dropped with bReadyOut=1; no output byte; exp stays 117.
- Backpressure: forwarding a 20-byte packet with outReadyIn toggling every cycle.
  - Required: 20 bytes out in order, outLastOut only on byte 20, the source feed stalled in lockstep.
- Reset mid-packet: assert rstIn on byte 5 of a forwarded packet.
  - Required: next cycle all outputs are 0 and synced=0.
  - Required: the next packet seq=500 is forwarded with no gap, and exp=500+cnt.

Source files
------------

// File: rtl/mold_feed_arbiter.sv
// A/B MoldUDP64 line arbiter: forwards each sequence range once, in order,
// dropping duplicates and heartbeats and flagging sequence gaps.
module mold_feed_arbiter #(
    parameter int SEQ_W  = 64,
    parameter int CNT_W  = 16,
    parameter int STAT_W = 32
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              aValidIn,
    input  logic [7:0]        aDataIn,
    input  logic              aLastIn,
    input  logic [SEQ_W-1:0]  aSeqNumIn,
    input  logic [CNT_W-1:0]  aMsgCntIn,
    output logic              aReadyOut,
    input  logic              bValidIn,
    input  logic [7:0]        bDataIn,
    input  logic              bLastIn,
    input  logic [SEQ_W-1:0]  bSeqNumIn,
    input  logic [CNT_W-1:0]  bMsgCntIn,
    output logic              bReadyOut,
    output logic              outValidOut,
    output logic [7:0]        outDataOut,
    output logic              outLastOut,
    input  logic              outReadyIn,
    output logic              gapOut,
    output logic [STAT_W-1:0] gapSizeOut,
    output logic [SEQ_W-1:0]  expSeqNumOut,
    output logic              syncedOut,
    output logic [STAT_W-1:0] dupDropCntOut,
    output logic [STAT_W-1:0] gapCntOut
);
    typedef enum logic [2:0] {IDLE, FWD_A, FWD_B, DROP_A, DROP_B} state_t;

    state_t            state_q, state_d;
    logic              last_grant_b_q, last_grant_b_d;
    logic [SEQ_W-1:0]  exp_q, exp_d;
    logic              synced_q, synced_d;
    logic              gap_q, gap_d;
    logic [STAT_W-1:0] gap_size_q, gap_size_d;
    logic [STAT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic [STAT_W-1:0] gap_cnt_q, gap_cnt_d;

    logic              pick_b;
    logic [SEQ_W-1:0]  win_seq, win_end, gap_diff;
    logic [CNT_W-1:0]  win_cnt;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    // Lower sequence wins; ties go to the feed that did not win last time.
    always_comb begin
        pick_b = bValidIn;
        if (aValidIn && bValidIn) begin
            if (bSeqNumIn < aSeqNumIn)       pick_b = 1'b1;
            else if (bSeqNumIn == aSeqNumIn) pick_b = !last_grant_b_q;
            else                             pick_b = 1'b0;
        end
        win_seq  = pick_b ? bSeqNumIn : aSeqNumIn;
        win_cnt  = pick_b ? bMsgCntIn : aMsgCntIn;
        win_end  = win_seq + SEQ_W'(win_cnt);
        gap_diff = win_seq - exp_q;
    end

    always_comb begin
        state_d        = state_q;
        last_grant_b_d = last_grant_b_q;
        exp_d          = exp_q;
        synced_d       = synced_q;
        gap_d          = 1'b0;
        gap_size_d     = gap_size_q;
        dup_cnt_d      = dup_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        aReadyOut      = 1'b0;
        bReadyOut      = 1'b0;
        outValidOut    = 1'b0;
        outDataOut     = 8'h00;
        outLastOut     = 1'b0;

        case (state_q)
            IDLE: begin
                if (aValidIn || bValidIn) begin
                    last_grant_b_d = pick_b;
                    if (win_cnt == '0 || (synced_q && win_end <= exp_q)) begin
                        state_d   = pick_b ? DROP_B : DROP_A;
                        dup_cnt_d = sat_inc(dup_cnt_q);
                    end else begin
                        state_d  = pick_b ? FWD_B : FWD_A;
                        exp_d    = win_end;
                        synced_d = 1'b1;
                        if (synced_q && win_seq > exp_q) begin
                            gap_d      = 1'b1;
                            gap_size_d = (gap_diff > SEQ_W'({STAT_W{1'b1}})) ?
                                         {STAT_W{1'b1}} : gap_diff[STAT_W-1:0];
                            gap_cnt_d  = sat_inc(gap_cnt_q);
                        end
                    end
                end
            end
            FWD_A: begin
                outValidOut = aValidIn;
                outDataOut  = aDataIn;
                outLastOut  = aLastIn;
                aReadyOut   = outReadyIn;
                if (aValidIn && outReadyIn && aLastIn) state_d = IDLE;
            end
            FWD_B: begin
                outValidOut = bValidIn;
                outDataOut  = bDataIn;
                outLastOut  = bLastIn;
                bReadyOut   = outReadyIn;
                if (bValidIn && outReadyIn && bLastIn) state_d = IDLE;
            end
            DROP_A: begin
                aReadyOut = 1'b1;
                if (aValidIn && aLastIn) state_d = IDLE;
            end
            DROP_B: begin
                bReadyOut = 1'b1;
                if (bValidIn && bLastIn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q        <= IDLE;
            last_grant_b_q <= 1'b1;
            exp_q          <= '0;
            synced_q       <= 1'b0;
            gap_q          <= 1'b0;
            gap_size_q     <= '0;
            dup_cnt_q      <= '0;
            gap_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_b_q <= last_grant_b_d;
            exp_q          <= exp_d;
            synced_q       <= synced_d;
            gap_q          <= gap_d;
            gap_size_q     <= gap_size_d;
            dup_cnt_q      <= dup_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign gapOut        = gap_q;
    assign gapSizeOut    = gap_size_q;
    assign expSeqNumOut  = exp_q;
    assign syncedOut     = synced_q;
    assign dupDropCntOut = dup_cnt_q;
    assign gapCntOut     = gap_cnt_q;
endmodule

// File: tb/tb_mold_feed_arbiter.sv
// Scoreboard bench for mold_feed_arbiter: directed packets on feeds A/B,
// expected output bytes queued at issue time and checked by a monitor.
module tb_mold_feed_arbiter;
    localparam int SEQ_W  = 64;
    localparam int CNT_W  = 16;
    localparam int STAT_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, a_last, a_ready;
    logic [7:0]        a_data;
    logic [SEQ_W-1:0]  a_seq;
    logic [CNT_W-1:0]  a_cnt;
    logic              b_valid, b_last, b_ready;
    logic [7:0]        b_data;
    logic [SEQ_W-1:0]  b_seq;
    logic [CNT_W-1:0]  b_cnt;
    logic              out_valid, out_last, out_ready;
    logic [7:0]        out_data;
    logic              gap_o, synced_o;
    logic [STAT_W-1:0] gap_size_o, dup_cnt_o, gap_cnt_o;
    logic [SEQ_W-1:0]  exp_o;

    always #5 clk = ~clk;

    mold_feed_arbiter #(.SEQ_W(SEQ_W), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clkIn(clk), .rstIn(rst),
        .aValidIn(a_valid), .aDataIn(a_data), .aLastIn(a_last),
        .aSeqNumIn(a_seq), .aMsgCntIn(a_cnt), .aReadyOut(a_ready),
        .bValidIn(b_valid), .bDataIn(b_data), .bLastIn(b_last),
        .bSeqNumIn(b_seq), .bMsgCntIn(b_cnt), .bReadyOut(b_ready),
        .outValidOut(out_valid), .outDataOut(out_data), .outLastOut(out_last),
        .outReadyIn(out_ready),
        .gapOut(gap_o), .gapSizeOut(gap_size_o), .expSeqNumOut(exp_o),
        .syncedOut(synced_o), .dupDropCntOut(dup_cnt_o), .gapCntOut(gap_cnt_o)
    );

    int         tests = 0;
    int         fails = 0;
    logic [8:0] sb[$];
    int         gap_hi = 0;
    bit         bp_en = 1'b0;
    bit         saw_b_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (gap_o) gap_hi++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h required none", {out_last, out_data});
                end else begin
                    check("out_byte", {55'd0, out_last, out_data}, {55'd0, sb.pop_front()});
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        if (bp_en) begin
            #2;
            out_ready = ~out_ready;
        end
    end

    task automatic push_pkt(input logic [7:0] base, input int len, input int n);
        for (int i = 0; i < n; i++) sb.push_back({(i == len - 1), base + 8'(i)});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one packet; with stop_at >= 0 it returns with that byte still presented.
    task automatic send_pkt(input bit side_b, input logic [63:0] seq, input logic [15:0] cnt,
                            input int len, input logic [7:0] base, input int stop_at);
        bit hs;
        int budget;
        for (int i = 0; i < len; i++) begin
            if (side_b) begin
                b_valid = 1'b1; b_data = base + 8'(i); b_last = (i == len - 1);
                b_seq = seq; b_cnt = cnt;
            end else begin
                a_valid = 1'b1; a_data = base + 8'(i); a_last = (i == len - 1);
                a_seq = seq; a_cnt = cnt;
            end
            if (i == stop_at) return;
            hs = 1'b0;
            budget = 0;
            while (!hs) begin
                @(negedge clk);
                hs = side_b ? (b_valid && b_ready) : (a_valid && a_ready);
                if (side_b && b_ready) saw_b_ready = 1'b1;
                @(posedge clk);
                #1;
                budget++;
                if (!hs && budget > 300) begin
                    tests++;
                    fails++;
                    $display("FAIL handshake_timeout: side %0d byte %0d not accepted, required accept", side_b, i);
                    if (side_b) b_valid = 1'b0; else a_valid = 1'b0;
                    return;
                end
            end
        end
        if (side_b) begin b_valid = 1'b0; b_last = 1'b0; end
        else        begin a_valid = 1'b0; a_last = 1'b0; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    int gap_before;

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 0; a_data = 0; a_last = 0; a_seq = 0; a_cnt = 0;
        b_valid = 0; b_data = 0; b_last = 0; b_seq = 0; b_cnt = 0;
        wait_cyc(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_exp", exp_o, 0);
        check("rst_synced", synced_o, 0);
        check("rst_dup", dup_cnt_o, 0);
        check("rst_gap_cnt", gap_cnt_o, 0);
        check("rst_gap_size", gap_size_o, 0);
        rst = 1'b0;
        wait_cyc(1);

        // Identical packets on both feeds: A wins the tie, B is a duplicate.
        push_pkt(8'h10, 4, 4);
        fork
            begin send_pkt(1'b0, 100, 3, 4, 8'h10, -1); check("sync_exp_after_a", exp_o, 103); end
            send_pkt(1'b1, 100, 3, 4, 8'h20, -1);
        join
        wait_cyc(3);
        check("sync_exp", exp_o, 103);
        check("sync_dup", dup_cnt_o, 1);
        check("sync_synced", synced_o, 1);
        check("sync_no_gap", gap_hi, 0);

        // Gap of 7 messages.
        push_pkt(8'h30, 3, 3);
        send_pkt(1'b0, 110, 2, 3, 8'h30, -1);
        wait_cyc(3);
        check("gap_pulses", gap_hi, 1);
        check("gap_size", gap_size_o, 7);
        check("gap_cnt", gap_cnt_o, 1);
        check("gap_exp", exp_o, 112);

        // Overlapping B (lower seq) first, then A with a gap of 1.
        push_pkt(8'h50, 3, 3);
        push_pkt(8'h40, 3, 3);
        fork
            send_pkt(1'b0, 115, 2, 3, 8'h40, -1);
            begin send_pkt(1'b1, 110, 4, 3, 8'h50, -1); check("ovl_exp_after_b", exp_o, 114); end
        join
        wait_cyc(3);
        check("ovl_exp", exp_o, 117);
        check("ovl_gap_size", gap_size_o, 1);
        check("ovl_gap_cnt", gap_cnt_o, 2);
        check("ovl_gap_pulses", gap_hi, 2);

        // Heartbeat on B.
        saw_b_ready = 1'b0;
        send_pkt(1'b1, 117, 0, 1, 8'h60, -1);
        wait_cyc(3);
        check("hb_b_ready", saw_b_ready, 1);
        check("hb_exp", exp_o, 117);
        check("hb_dup", dup_cnt_o, 2);

        // 20-byte packet with downstream ready toggling each cycle.
        push_pkt(8'h70, 20, 20);
        bp_en = 1'b1;
        send_pkt(1'b0, 117, 5, 20, 8'h70, -1);
        bp_en = 1'b0;
        wait_cyc(2);
        out_ready = 1'b1;
        wait_cyc(2);
        check("bp_exp", exp_o, 122);
        check("bp_sb_empty", sb.size(), 0);

        // Reset while byte 5 of a forwarded packet is presented.
        push_pkt(8'h90, 8, 4);
        send_pkt(1'b0, 122, 3, 8, 8'h90, 4);
        rst = 1'b1;
        a_valid = 1'b0; a_last = 1'b0;
        wait_cyc(1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_a_ready", a_ready, 0);
        check("mid_rst_synced", synced_o, 0);
        check("mid_rst_exp", exp_o, 0);
        check("mid_rst_dup", dup_cnt_o, 0);
        rst = 1'b0;
        wait_cyc(1);
        gap_before = gap_hi;
        push_pkt(8'hA0, 2, 2);
        send_pkt(1'b0, 500, 4, 2, 8'hA0, -1);
        wait_cyc(3);
        check("post_rst_exp", exp_o, 504);
        check("post_rst_synced", synced_o, 1);
        check("post_rst_no_gap", gap_hi - gap_before, 0);
        check("post_rst_gap_cnt", gap_cnt_o, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
